// File: rtl/mem_arbiter_pkg.sv
// Shared types and width defaults for the two-port (CPU/DMA) memory arbiter.
package lc3b_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DMA = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_lat_counter.sv
// Latency down-counter: loads a start value, decrements to zero and holds there.
module mem_lat_counter
    import lc3b_mem_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// CPU/DMA shared-memory arbiter: IDLE -> ACCESS (LATENCY cycles) -> DONE (ready pulse).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed CPU priority.
//   state  | meaning
//   IDLE   | bus idle, arbitrate among pending requests
//   ACCESS | memory enabled with latched request, counting LATENCY cycles
//   DONE   | one-cycle ready pulse to the granted port
module mem_arbiter
    import lc3b_mem_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_r,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_r,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    grant_e            grant_q, grant_d;
    grant_e            win;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              cnt_load, cnt_dec, cnt_zero;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    grant_e last_grant_q, last_grant_d;

    always_comb begin
        if (cpu_req && dma_req) begin
            win = (last_grant_q == GNT_CPU) ? GNT_DMA : GNT_CPU;
        end else begin
            win = cpu_req ? GNT_CPU : GNT_DMA;
        end
    end
`else
    assign win = cpu_req ? GNT_CPU : GNT_DMA;
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    grant_d  = win;
                    we_d     = (win == GNT_CPU) ? cpu_we    : dma_we;
                    addr_d   = (win == GNT_CPU) ? cpu_addr  : dma_addr;
                    wdata_d  = (win == GNT_CPU) ? cpu_wdata : dma_wdata;
                    cnt_load = 1'b1;
                    state_d  = ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    last_grant_d = win;
`endif
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    // Memory data is only guaranteed valid in the final access cycle.
                    if (!we_q) begin
                        if (grant_q == GNT_CPU) cpu_rdata_d = mem_rdata;
                        else                    dma_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            grant_q     <= GNT_CPU;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_grant_q <= GNT_DMA;
        else        last_grant_q <= last_grant_d;
    end
`endif

    mem_lat_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = mem_en ? addr_q  : '0;
    assign mem_wdata = mem_en ? wdata_q : '0;
    assign cpu_r     = (state_q == DONE) && (grant_q == GNT_CPU);
    assign dma_r     = (state_q == DONE) && (grant_q == GNT_DMA);
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: LATENCY=4 instance plus a LATENCY=1 instance.
module tb_mem_arbiter;

    localparam int LAT = 4;

    typedef struct packed {
        logic        dma;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic        cpu_r, dma_r, mem_en, mem_we;

    logic        l1_cpu_req;
    logic [15:0] l1_cpu_addr, l1_mem_rdata;
    logic [15:0] l1_cpu_rdata, l1_dma_rdata, l1_mem_addr, l1_mem_wdata;
    logic        l1_cpu_r, l1_dma_r, l1_mem_en, l1_mem_we;

    exp_t        q[$];
    exp_t        q1[$];
    logic [15:0] mdl [2];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.LATENCY(LAT), .ADDR_W(16), .DATA_W(16)) dut (
        .clk(clk), .reset(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_r(cpu_r),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_r(dma_r),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.LATENCY(1), .ADDR_W(16), .DATA_W(16)) u1 (
        .clk(clk), .reset(rst_n),
        .cpu_req(l1_cpu_req), .cpu_we(1'b0), .cpu_addr(l1_cpu_addr), .cpu_wdata(16'h0),
        .cpu_rdata(l1_cpu_rdata), .cpu_r(l1_cpu_r),
        .dma_req(1'b0), .dma_we(1'b0), .dma_addr(16'h0), .dma_wdata(16'h0),
        .dma_rdata(l1_dma_rdata), .dma_r(l1_dma_r),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
        .mem_rdata(l1_mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitors: every ready pulse must match the oldest expected response.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_r && dma_r) begin
            check("r_both_high", 32'(cpu_r & dma_r), 32'd0);
        end else if (cpu_r || dma_r) begin
            if (q.size() == 0) begin
                check("r_unexpected", 32'(cpu_r | dma_r), 32'd0);
            end else begin
                e = q.pop_front();
                check("r_port", 32'(dma_r), 32'(e.dma));
                check("r_rdata", 32'(dma_r ? dma_rdata : cpu_rdata), 32'(e.data));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (l1_cpu_r || l1_dma_r) begin
            if (q1.size() == 0 || l1_dma_r) begin
                check("l1_r_unexpected", 32'(l1_dma_r), 32'd0);
                check("l1_r_unexpected_q", 32'(q1.size()), 32'd1);
            end else begin
                e = q1.pop_front();
                check("l1_r_rdata", 32'(l1_cpu_rdata), 32'(e.data));
            end
        end
    end

    task automatic run_txn(input logic dma, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [15:0] mdata, input logic drop);
        exp_t e;
        @(negedge clk);
        if (dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
        else     begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
        e.dma  = dma;
        e.data = we ? mdl[dma] : mdata;
        if (!we) mdl[dma] = mdata;
        q.push_back(e);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("acc_en", 32'(mem_en), 32'd1);
            check("acc_we", 32'(mem_we), 32'(we));
            check("acc_addr", 32'(mem_addr), 32'(addr));
            check("acc_wdata", 32'(mem_wdata), 32'(wdata));
            mem_rdata = (i == LAT - 1) ? mdata : ~mdata;
            if (i == 0) begin
                cpu_addr = ~cpu_addr; dma_addr = ~dma_addr;
                cpu_wdata = ~cpu_wdata; dma_wdata = ~dma_wdata;
                cpu_we = ~cpu_we; dma_we = ~dma_we;
                if (drop) begin cpu_req = 0; dma_req = 0; end
            end
        end
        @(negedge clk);
        mem_rdata = 16'h0;
        check("done_en", 32'(mem_en), 32'd0);
        check("done_addr", 32'(mem_addr), 32'd0);
        check("done_r", 32'(dma ? dma_r : cpu_r), 32'd1);
        check("done_other_r", 32'(dma ? cpu_r : dma_r), 32'd0);
        @(negedge clk);
        cpu_req = 0; dma_req = 0;
        check("idle_en", 32'(mem_en), 32'd0);
        @(negedge clk);
        check("idle_no_restart", 32'(mem_en), 32'd0);
    endtask

    initial begin
        logic [15:0] dk [3];
        logic        wins [3];
        exp_t        e;
        dk = '{16'hD00D, 16'hE00E, 16'hF00F};
`ifdef MEM_ARB_ROUND_ROBIN_EN
        wins = '{1'b0, 1'b1, 1'b0};
`else
        wins = '{1'b0, 1'b0, 1'b0};
`endif
        mdl = '{16'h0, 16'h0};
        rst_n = 0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; mem_rdata = 0;
        l1_cpu_req = 0; l1_cpu_addr = 0; l1_mem_rdata = 0;
        repeat (2) @(negedge clk);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_r", 32'({cpu_r, dma_r}), 32'd0);
        check("rst_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
        rst_n = 1;

        run_txn(1'b0, 1'b0, 16'h3000, 16'h0000, 16'hBEEF, 1'b0);
        run_txn(1'b1, 1'b0, 16'h4000, 16'h0000, 16'hCAFE, 1'b0);
        run_txn(1'b1, 1'b1, 16'h4002, 16'h1234, 16'h5555, 1'b0);
        run_txn(1'b0, 1'b1, 16'h3001, 16'hA5A5, 16'h7777, 1'b1);
        run_txn(1'b0, 1'b0, 16'h3002, 16'h0000, 16'h0F0F, 1'b1);

        // Reset during the second access cycle aborts without a ready pulse.
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h5000;
        @(negedge clk);
        check("pre_rst_en", 32'(mem_en), 32'd1);
        @(negedge clk);
        #2 rst_n = 0;
        #1;
        check("rst_abort_en", 32'(mem_en), 32'd0);
        check("rst_abort_addr", 32'(mem_addr), 32'd0);
        check("rst_abort_r", 32'({cpu_r, dma_r}), 32'd0);
        check("rst_abort_rdata", 32'({cpu_rdata, dma_rdata}), 32'd0);
        cpu_req = 0;
        mdl = '{16'h0, 16'h0};
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", 32'(mem_en), 32'd0);
        end

        // Both requesters held high over three transactions.
        @(negedge clk);
        cpu_req = 1; dma_req = 1; cpu_we = 0; dma_we = 0;
        cpu_addr = 16'h1000; dma_addr = 16'h2000;
        for (int k = 0; k < 3; k++) begin
            e.dma = wins[k];
            e.data = dk[k];
            mdl[wins[k]] = dk[k];
            q.push_back(e);
            for (int i = 0; i < LAT; i++) begin
                @(negedge clk);
                check("arb_addr", 32'(mem_addr), wins[k] ? 32'h2000 : 32'h1000);
                mem_rdata = (i == LAT - 1) ? dk[k] : 16'h0;
            end
            @(negedge clk);
            mem_rdata = 16'h0;
            if (k == 2) begin cpu_req = 0; dma_req = 0; end
            @(negedge clk);
        end
        @(negedge clk);
        check("arb_end_idle", 32'(mem_en), 32'd0);
        check("arb_dma_rdata", 32'(dma_rdata), 32'(mdl[1]));

        // LATENCY=1 instance.
        @(negedge clk);
        l1_cpu_req = 1; l1_cpu_addr = 16'h6000;
        e.dma = 1'b0; e.data = 16'h1357;
        q1.push_back(e);
        @(negedge clk);
        check("l1_acc_en", 32'(l1_mem_en), 32'd1);
        check("l1_acc_addr", 32'(l1_mem_addr), 32'h6000);
        l1_mem_rdata = 16'h1357;
        @(negedge clk);
        l1_mem_rdata = 16'h0;
        check("l1_done_r", 32'(l1_cpu_r), 32'd1);
        check("l1_done_en", 32'(l1_mem_en), 32'd0);
        @(negedge clk);
        l1_cpu_req = 0;
        check("l1_idle_en", 32'(l1_mem_en), 32'd0);
        @(negedge clk);
        check("l1_no_restart", 32'(l1_mem_en), 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 32'd0);
        check("l1_scoreboard_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 Parameter LATENCY, default 4: memory access cycles per transaction, legal range 1..15.
- REQ-002 Parameter ADDR_W, default 16: address width.
- REQ-003 Parameter DATA_W, default 16: data width.
- REQ-004 clk  in  1  single system clock, all state on rising edge.
- REQ-005 reset  in  1  asynchronous, active-low reset.
- REQ-006 cpu_req  in  1  control-unit memory request (MEMEN), held until cpu_r.
- REQ-007 cpu_we  in  1  1 = write, 0 = read.
- REQ-008 cpu_addr  in  ADDR_W  CPU address (MAR).
- REQ-009 cpu_wdata  in  DATA_W  CPU write data (MDR).
- REQ-010 cpu_rdata  out  DATA_W  CPU read data.
- REQ-011 cpu_r  out  1  CPU ready (R), one-cycle pulse.
- REQ-012 dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_r: same widths and meanings as the cpu_* ports, for the DMA requester.
- REQ-013 mem_en  out  1  memory enable to the shared memory.
- REQ-014 mem_we  out  1  memory write enable.
- REQ-015 mem_addr  out  ADDR_W  memory address.
- REQ-016 mem_wdata  out  DATA_W  memory write data.
- REQ-017 mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle.

Function
- REQ-018 The FSM SHALL have three states: IDLE, ACCESS and DONE.
- REQ-019 Arbitration SHALL occur only in IDLE. Any asserted req SHALL cause, on the next edge: grant, latch of the winner's we/addr/wdata, counter load LATENCY-1, and entry to ACCESS.
- REQ-020 In ACCESS, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values. In IDLE and DONE, all mem_* outputs SHALL be 0.
- REQ-021 ACCESS SHALL last exactly LATENCY cycles. At counter 0, mem_rdata SHALL be captured into the granted port's rdata register (reads only) and the FSM SHALL go to DONE.
- REQ-022 In DONE, only the granted port's r SHALL be 1, for exactly one cycle. The FSM SHALL then return to IDLE unconditionally.
- REQ-023 Latency: req first seen in IDLE at cycle 0 -> r high in cycle LATENCY+1. The minimum spacing between back-to-back transactions is LATENCY+2 cycles.
- REQ-024 An rdata register SHALL hold its value until that port's next read completes. A write SHALL leave rdata unchanged.
- REQ-025 If req drops during ACCESS, the access SHALL still complete and r SHALL still pulse.
- REQ-026 Changes to req/addr/wdata during ACCESS SHALL have no effect on the mem_* outputs.
- REQ-027 A req still high in the DONE cycle SHALL NOT be counted as a new request. Arbitration resumes in the following IDLE cycle.

Reset
- REQ-028 Reset SHALL take effect immediately on assertion: FSM to IDLE, counter 0, all r and mem_* outputs 0, both rdata registers 0, last_grant = DMA.
- REQ-029 Reset asserted mid-ACCESS SHALL abort the transaction with no r pulse. Deassertion SHALL be sampled on clk.

Configuration
- REQ-030 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the port not granted last SHALL win, and last_grant SHALL update on every grant.
- REQ-031 Macro undefined: CPU SHALL have fixed priority over DMA, and last_grant logic SHALL be absent.

Structure
- REQ-032 Shared package lc3b_mem_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), the grant enum (GNT_CPU/GNT_DMA), and the ADDR_W/DATA_W defaults.
- REQ-033 One sub-module, mem_lat_counter, SHALL implement the 4-bit load/decrement latency counter with a zero flag. Arbitration and the FSM SHALL stay in mem_arbiter.

Verification
- REQ-034 CPU read, LATENCY=4, addr 0x3000, mem_rdata 0xBEEF -> mem_en high cycles 1-4, cpu_r pulses in cycle 5, cpu_rdata=0xBEEF, dma_r stays 0.
- REQ-035 DMA write, addr 0x4002, wdata 0x1234 -> mem_we=1, mem_addr=0x4002, mem_wdata=0x1234 for 4 cycles, then dma_r pulse, and dma_rdata unchanged.
- REQ-036 Both requesters held high, three transactions -> with the macro, grants CPU, DMA, CPU. Without the macro, grants CPU, CPU, CPU.
- REQ-037 Reset asserted in the 2nd ACCESS cycle -> mem_en=0 immediately, no r pulse, and after release an idle bus until a new req.
- REQ-038 LATENCY=1, CPU read -> mem_en high for 1 cycle, cpu_r in cycle 2. cpu_addr changed mid-access in a LATENCY=4 run -> mem_addr holds the original value.
